// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants for the 4:1 mux round-robin arbiter: FSM encodings,
// reset value of the last-winner pointer and the requester count.
package mux_arb_pkg;

  localparam int NREQ = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  // Last-winner pointer after reset; 2'b11 makes A the first candidate.
  localparam logic [1:0] PTR_RST = 2'b11;

  // One-hot vector for a requester index.
  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Bus between the four producers / single consumer and the arbiter.
// slave = arbiter side, master = producer/consumer side.
interface mux4_rr_arbiter_if #(parameter int n = 4);
  import mux_arb_pkg::*;

  logic [NREQ-1:0] req;
  logic [n-1:0]    A;
  logic [n-1:0]    B;
  logic [n-1:0]    C;
  logic [n-1:0]    D;
  logic [NREQ-1:0] ack;
  logic [1:0]      S;
  logic [NREQ-1:0] grant;
  logic [n-1:0]    Y;
  logic            out_valid;
  logic            out_ready;

  modport slave (
    input  req, A, B, C, D, out_ready,
    output ack, S, grant, Y, out_valid
  );

  modport master (
    output req, A, B, C, D, out_ready,
    input  ack, S, grant, Y, out_valid
  );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational winner selection over four eligible requests.
// Default: round-robin starting after the last winner.
// ARB_FIXED_PRIO_EN: fixed priority A>B>C>D, pointer ignored.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic [1:0]      i_ptr,
  output logic [1:0]      o_winner,
  output logic            o_any
);

  assign o_any = |i_req;

`ifdef ARB_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  // Lowest requesting index wins; scan downward so the lowest overwrites last.
  always_comb begin
    o_winner = 2'b00;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[k]) o_winner = 2'(k);
    end
  end
`else
  // Scan from ptr+4 (the pointer itself, lowest priority) down to ptr+1 so
  // the nearest index after the last winner overwrites last and wins.
  always_comb begin
    o_winner = 2'b00;
    for (int k = NREQ; k >= 1; k--) begin
      if (i_req[2'(i_ptr + 2'(k))]) o_winner = 2'(i_ptr + 2'(k));
    end
  end
`endif

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four requesters share one n-bit 4:1 mux; the winner's word is captured
// into Y and offered downstream with valid/ready. Back-to-back capture when
// the consumer accepts and another eligible request is pending.
// Optional macro ARB_FIXED_PRIO_EN selects fixed A>B>C>D priority.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int n = 4
) (
  input  logic              clk,
  input  logic              rst,
  mux4_rr_arbiter_if.slave  bus
);

  logic [0:0]      r_state;
  logic [1:0]      r_ptr;
  logic [n-1:0]    r_y;
  logic [1:0]      r_s;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_ack;

  logic [NREQ-1:0] w_elig;
  logic [1:0]      w_winner;
  logic            w_any;
  logic            w_take;
  logic [n-1:0]    w_word;

  // A request acknowledged this cycle is still high; keep it out of the race.
  assign w_elig = bus.req & ~r_ack;

  rr_pick4 u_pick (
    .i_req    (w_elig),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // Capture whenever the output slot is free or being freed this cycle.
  assign w_take = w_any && ((r_state == IDLE) || bus.out_ready);

  // Shared 4:1 data mux driven by the current winner.
  always_comb begin
    w_word = bus.A;
    case (w_winner)
      2'd0:    w_word = bus.A;
      2'd1:    w_word = bus.B;
      2'd2:    w_word = bus.C;
      default: w_word = bus.D;
    endcase
  end

  // Arbitration FSM, output register and last-winner pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= PTR_RST;
      r_y     <= '0;
      r_s     <= 2'b00;
      r_grant <= '0;
      r_ack   <= '0;
    end else begin
      r_ack <= '0;
      if (w_take) begin
        r_state <= FULL;
        r_y     <= w_word;
        r_s     <= w_winner;
        r_grant <= onehot4(w_winner);
        r_ptr   <= w_winner;
        r_ack   <= onehot4(w_winner);
      end else if ((r_state == FULL) && bus.out_ready) begin
        r_state <= IDLE;
        r_grant <= '0;
      end
    end
  end

  assign bus.ack       = r_ack;
  assign bus.S         = r_s;
  assign bus.grant     = r_grant;
  assign bus.Y         = r_y;
  assign bus.out_valid = (r_state == FULL);

endmodule
